knn_vote: RTL
=============

KNN_VOTE -- requirements
Module: knn_vote

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as the codebase names its clock and reset ports.
REQ-002 Parameter K, default 10: number of nearest neighbours that vote.
REQ-003 Parameter N_CLASSES, default 4: number of valid class labels, 0..N_CLASSES-1.
REQ-004 Parameter LABEL_W, default 8: label width.
REQ-005 Parameter SEL_W, default clog2(K): neighbour index width.
REQ-006 clk  in  1  system clock.
REQ-007 rst  in  1  asynchronous active-low reset.
REQ-008 start  in  1  one-cycle request to begin a vote.
REQ-009 sort_done  in  1  upstream sorter list-complete flag (level).
REQ-010 sel  out  SEL_W  index of the neighbour being read, 0 = nearest.
REQ-011 label_in  in  LABEL_W  label of neighbour[sel]; combinational from sel, valid in the same cycle.
REQ-012 busy  out  1  high from an accepted start until done.
REQ-013 done  out  1  one-cycle pulse when the result is valid.
REQ-014 class_out  out  LABEL_W  winning class.
REQ-015 votes_out  out  clog2(K+1)  vote count of the winning class.
REQ-016 label_err  out  1  sticky per vote; set when any label_in >= N_CLASSES.

Function
REQ-017 FSM states: IDLE, WAIT, READ, DECIDE, FIN.
REQ-018 IDLE: start=1 moves to WAIT, clears all per-class counters, first-index registers, label_err, and sel.
REQ-019 start while busy=1 SHALL be ignored.
REQ-020 WAIT: stay while sort_done=0; on sort_done=1 move to READ next cycle.
REQ-021 READ: one neighbour per cycle; sel counts 0..K-1.
REQ-022 READ: each cycle, count[label_in] increments.
REQ-023 READ: if count[label_in] was 0, first_idx[label_in] is set to sel.
REQ-024 READ: label_in >= N_CLASSES increments no counter and sets label_err.
REQ-025 READ: after sel=K-1, move to DECIDE; sel holds at K-1.
REQ-026 DECIDE: scan classes 0..N_CLASSES-1, one per cycle.
REQ-027 DECIDE: a class replaces the best if its count > best count, or if counts are equal, non-zero, and its first_idx < best first_idx (nearest-neighbour tie-break).
REQ-028 DECIDE: after the last class, move to FIN.
REQ-029 FIN: done=1 for one cycle, class_out and votes_out update, then return to IDLE.
REQ-030 class_out and votes_out SHALL hold until the next FIN.
REQ-031 Latency: start accepted with sort_done already 1 in cycle 0 gives done in cycle K+N_CLASSES+2.
REQ-032 Counters SHALL be clog2(K+1) bits wide and SHALL never wrap; the maximum count is K.
REQ-033 If all labels are invalid: class_out=0, votes_out=0, label_err=1.
REQ-034 sort_done dropping during READ SHALL be ignored; the vote completes.
REQ-035 busy = (state != IDLE).

Reset
REQ-036 Asserting rst at any time, including mid-vote, SHALL force state to IDLE, with busy=0, done=0, sel=0, class_out=0, votes_out=0, label_err=0, and all counters cleared.
REQ-037 The block SHALL leave reset cleanly on the first clock edge after rst deasserts.

Structure
REQ-038 A shared package SHALL hold the FSM state encoding, the default K/N_CLASSES/LABEL_W values, and the clog2 helper.
REQ-039 The counter bank SHALL be one sub-module, knn_vote_cnt, with clear, inc, idx, count, and first_idx ports.
REQ-040 The design SHALL have no other hierarchy.

Verification
REQ-041 Bench: K=5, N_CLASSES=4, sort_done=1; labels 2,1,2,3,2 -> done at cycle 11, class_out=2, votes_out=3, label_err=0.
REQ-042 Bench: labels 1,3,3,1,0 (tie between 1 and 3) -> class_out=1 (first_idx 0 < 1), votes_out=2.
REQ-043 Bench: start with sort_done=0 for 7 cycles, then 1 -> READ starts the cycle after sort_done rises; busy stays 1 throughout WAIT.
REQ-044 Bench: labels 7,9,2,8,8 -> class_out=2, votes_out=1, label_err=1.
REQ-045 Bench: assert rst during READ at sel=2 -> all outputs 0 immediately; a new start yields a correct, independent vote.
REQ-046 Bench: second start pulse during DECIDE -> ignored; exactly one done pulse.

Source files
------------

// File: rtl/knn_vote_pkg.sv
// rtl/knn_vote_pkg.sv - shared state encoding, default sizes and clog2 helper for knn_vote
package knn_vote_pkg;

    localparam int K_DEF         = 10;
    localparam int N_CLASSES_DEF = 4;
    localparam int LABEL_W_DEF   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READ,
        ST_DECIDE,
        ST_FIN
    } state_e;

    // Never returns less than 1 so a degenerate size still yields a legal port width.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/knn_vote_cnt.sv
// rtl/knn_vote_cnt.sv - per-class vote counters with first-occurrence neighbour index
module knn_vote_cnt
    import knn_vote_pkg::*;
#(
    parameter int K         = K_DEF,
    parameter int N_CLASSES = N_CLASSES_DEF,
    parameter int SEL_W     = clog2(K),
    parameter int CNT_W     = clog2(K + 1),
    parameter int CLS_W     = clog2(N_CLASSES)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             inc_i,
    input  logic [CLS_W-1:0] idx_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic [CNT_W-1:0] count_o,
    output logic [SEL_W-1:0] first_idx_o
);

    logic [CNT_W-1:0] cnt_q   [N_CLASSES];
    logic [SEL_W-1:0] first_q [N_CLASSES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < N_CLASSES; c++) begin
                cnt_q[c]   <= '0;
                first_q[c] <= '0;
            end
        end else if (clear_i) begin
            for (int c = 0; c < N_CLASSES; c++) begin
                cnt_q[c]   <= '0;
                first_q[c] <= '0;
            end
        end else if (inc_i) begin
            for (int c = 0; c < N_CLASSES; c++) begin
                if (idx_i == CLS_W'(c)) begin
                    if (cnt_q[c] == '0) first_q[c] <= sel_i;
                    // Saturate at K so a misbehaving sequencer can never wrap a count.
                    if (cnt_q[c] != CNT_W'(K)) cnt_q[c] <= cnt_q[c] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        count_o     = '0;
        first_idx_o = '0;
        for (int c = 0; c < N_CLASSES; c++) begin
            if (idx_i == CLS_W'(c)) begin
                count_o     = cnt_q[c];
                first_idx_o = first_q[c];
            end
        end
    end

endmodule

// File: rtl/knn_vote.sv
// rtl/knn_vote.sv - majority vote over the K nearest neighbour labels with nearest-first tie-break
module knn_vote
    import knn_vote_pkg::*;
#(
    parameter int K         = K_DEF,
    parameter int N_CLASSES = N_CLASSES_DEF,
    parameter int LABEL_W   = LABEL_W_DEF,
    parameter int SEL_W     = clog2(K)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic                     sort_done_i,
    output logic [SEL_W-1:0]         sel_o,
    input  logic [LABEL_W-1:0]       label_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [LABEL_W-1:0]       class_o,
    output logic [clog2(K+1)-1:0]    votes_o,
    output logic                     label_err_o
);

    localparam int CNT_W = clog2(K + 1);
    localparam int CLS_W = clog2(N_CLASSES);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CLS_W-1:0] cls_q, cls_d;
    logic [CLS_W-1:0] best_cls_q, best_cls_d;
    logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
    logic [SEL_W-1:0] best_first_q, best_first_d;
    logic [LABEL_W-1:0] class_q, class_d;
    logic [CNT_W-1:0] votes_q, votes_d;
    logic             err_q, err_d;

    logic             label_valid;
    logic             take;
    logic             cnt_clear;
    logic             cnt_inc;
    logic [CLS_W-1:0] cnt_idx;
    logic [CNT_W-1:0] cnt_count;
    logic [SEL_W-1:0] cnt_first;

    assign label_valid = (32'(label_i) < N_CLASSES);
    assign cnt_clear   = (state_q == ST_IDLE) && start_i;
    assign cnt_inc     = (state_q == ST_READ) && label_valid;
    // The bank has a single address: the incoming label while reading, the scan class while deciding.
    assign cnt_idx     = (state_q == ST_DECIDE) ? cls_q : label_i[CLS_W-1:0];

    knn_vote_cnt #(
        .K         (K),
        .N_CLASSES (N_CLASSES),
        .SEL_W     (SEL_W),
        .CNT_W     (CNT_W),
        .CLS_W     (CLS_W)
    ) u_cnt (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (cnt_clear),
        .inc_i       (cnt_inc),
        .idx_i       (cnt_idx),
        .sel_i       (sel_q),
        .count_o     (cnt_count),
        .first_idx_o (cnt_first)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            cls_q        <= '0;
            best_cls_q   <= '0;
            best_cnt_q   <= '0;
            best_first_q <= '1;
            class_q      <= '0;
            votes_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            cls_q        <= cls_d;
            best_cls_q   <= best_cls_d;
            best_cnt_q   <= best_cnt_d;
            best_first_q <= best_first_d;
            class_q      <= class_d;
            votes_q      <= votes_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        cls_d        = cls_q;
        best_cls_d   = best_cls_q;
        best_cnt_d   = best_cnt_q;
        best_first_d = best_first_q;
        class_d      = class_q;
        votes_d      = votes_q;
        err_d        = err_q;
        take         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d      = ST_WAIT;
                    sel_d        = '0;
                    err_d        = 1'b0;
                    best_cls_d   = '0;
                    best_cnt_d   = '0;
                    best_first_d = '1;
                end
            end
            ST_WAIT: begin
                if (sort_done_i) state_d = ST_READ;
            end
            ST_READ: begin
                if (!label_valid) err_d = 1'b1;
                if (sel_q == SEL_W'(K - 1)) begin
                    state_d = ST_DECIDE;
                    cls_d   = '0;
                end else begin
                    sel_d = sel_q + SEL_W'(1);
                end
            end
            ST_DECIDE: begin
                take = (cnt_count > best_cnt_q) ||
                       ((cnt_count == best_cnt_q) && (cnt_count != '0) && (cnt_first < best_first_q));
                if (take) begin
                    best_cls_d   = cls_q;
                    best_cnt_d   = cnt_count;
                    best_first_d = cnt_first;
                end
                // Publish on the last class so the result is already valid during the done cycle.
                if (cls_q == CLS_W'(N_CLASSES - 1)) begin
                    state_d = ST_FIN;
                    class_d = LABEL_W'(best_cls_d);
                    votes_d = best_cnt_d;
                end else begin
                    cls_d = cls_q + CLS_W'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sel_o       = sel_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_FIN);
    assign class_o     = class_q;
    assign votes_o     = votes_q;
    assign label_err_o = err_q;

endmodule
